// File: rtl/ibex_wb_buffer.sv
// ibex_wb_buffer: in-order writeback buffer between EX and the register-file
// write port. Results are queued in a small circular FIFO, drained whenever
// the LSU leaves the write port free, and offered to ID for forwarding.
// Optional feature macro: WB_SECURE_CLEAR_EN. When defined, freed entries are
// scrubbed and the write port data/address are held at zero unless a write
// strobe is issued.

module ibex_wb_buffer #(
    parameter int Depth      = 2,
    parameter int CountWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic [31:0]           ex_result_i,
    input  logic [4:0]            ex_waddr_i,
    input  logic                  ex_we_i,
    output logic                  ex_ready_o,
    output logic                  rf_we_o,
    output logic [4:0]            rf_waddr_o,
    output logic [31:0]           rf_wdata_o,
    input  logic                  rf_port_free_i,
    input  logic                  flush_i,
    input  logic [4:0]            fwd_raddr_i,
    output logic                  fwd_hit_o,
    output logic [31:0]           fwd_data_o,
    output logic                  empty_o,
    output logic [CountWidth-1:0] retired_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic              valid_q [Depth];
    logic              we_q    [Depth];
    logic [4:0]        waddr_q [Depth];
    logic [31:0]       data_q  [Depth];

    logic [PtrW-1:0]       head_q;
    logic [PtrW-1:0]       tail_q;
    logic [CntW-1:0]       count_q;
    logic [CountWidth-1:0] retired_q;

    logic            head_valid;
    logic            head_writes_rf;
    logic            push;
    logic            pop;
    logic [PtrW-1:0] fwd_idx;

    // Ready and empty come purely from the registered occupancy, so EX never
    // sees a combinational path from the LSU port arbitration.
    assign ex_ready_o = (count_q != CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign retired_o  = retired_q;

    assign head_valid     = valid_q[head_q];
    assign head_writes_rf = head_valid & we_q[head_q] & (waddr_q[head_q] != 5'd0);

    // Flush wins over both queue operations in the same cycle.
    assign push = ex_valid_i & ex_ready_o & ~flush_i;
    assign pop  = head_valid & rf_port_free_i & ~flush_i;

    assign rf_we_o = head_writes_rf & rf_port_free_i & ~flush_i;

`ifdef WB_SECURE_CLEAR_EN
    assign rf_waddr_o = rf_we_o ? waddr_q[head_q] : 5'd0;
    assign rf_wdata_o = rf_we_o ? data_q[head_q]  : 32'd0;
`else
    assign rf_waddr_o = waddr_q[head_q];
    assign rf_wdata_o = data_q[head_q];
`endif

    // Forwarding lookup: walk from oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'd0;
        fwd_idx    = head_q;
        for (int i = 0; i < Depth; i++) begin
            fwd_idx = head_q + PtrW'(i);
            if (valid_q[fwd_idx] && we_q[fwd_idx] &&
                (waddr_q[fwd_idx] == fwd_raddr_i) && (fwd_raddr_i != 5'd0)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[fwd_idx];
            end
        end
    end

    // Entry storage: reset clears everything, flush invalidates, push fills
    // the tail slot and pop frees the head slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                we_q[i]    <= 1'b0;
                waddr_q[i] <= 5'd0;
                data_q[i]  <= 32'd0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
`ifdef WB_SECURE_CLEAR_EN
                waddr_q[i] <= 5'd0;
                data_q[i]  <= 32'd0;
`endif
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
`ifdef WB_SECURE_CLEAR_EN
                waddr_q[head_q] <= 5'd0;
                data_q[head_q]  <= 32'd0;
`endif
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                we_q[tail_q]    <= ex_we_i;
                waddr_q[tail_q] <= ex_waddr_i;
                data_q[tail_q]  <= ex_result_i;
            end
        end
    end

    // Pointers, occupancy and retire counter; pointers wrap naturally since
    // Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            if (rst_i) begin
                retired_q <= '0;
            end
        end else begin
            if (push) begin
                tail_q <= tail_q + PtrW'(1);
            end
            if (pop) begin
                head_q    <= head_q + PtrW'(1);
                retired_q <= retired_q + CountWidth'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ibex_wb_buffer.sv
// tb_ibex_wb_buffer: directed scenarios plus randomized traffic for the
// writeback buffer, checked every cycle against a queue-based model.

module tb_ibex_wb_buffer;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic [31:0] ex_result_i = '0;
    logic [4:0]  ex_waddr_i = '0;
    logic        ex_we_i = 1'b0;
    logic        ex_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_port_free_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  fwd_raddr_i = '0;
    logic        fwd_hit_o;
    logic [31:0] fwd_data_o;
    logic        empty_o;
    logic [31:0] retired_o;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 1'b0;

    typedef struct {
        bit        we;
        bit [4:0]  waddr;
        bit [31:0] data;
    } entry_t;

    entry_t      modelQ[$];
    bit [31:0]   modelRetired = 0;

    ibex_wb_buffer #(.Depth(DEPTH), .CountWidth(32)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ex_valid_i     (ex_valid_i),
        .ex_result_i    (ex_result_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_we_i        (ex_we_i),
        .ex_ready_o     (ex_ready_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_port_free_i (rf_port_free_i),
        .flush_i        (flush_i),
        .fwd_raddr_i    (fwd_raddr_i),
        .fwd_hit_o      (fwd_hit_o),
        .fwd_data_o     (fwd_data_o),
        .empty_o        (empty_o),
        .retired_o      (retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic applyStimulus(input bit valid, input bit we, input bit [4:0] waddr,
                                 input bit [31:0] data, input bit free, input bit flush,
                                 input bit [4:0] raddr, input bit rst);
        @(negedge clk_i);
        rst_i          = rst;
        ex_valid_i     = valid;
        ex_we_i        = we;
        ex_waddr_i     = waddr;
        ex_result_i    = data;
        rf_port_free_i = free;
        flush_i        = flush;
        fwd_raddr_i    = raddr;
        #3;
    endtask

    task automatic idle(input bit free, input bit [4:0] raddr);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, free, 1'b0, raddr, 1'b0);
    endtask

    // Model comparison each cycle, then advance the model by one clock edge.
    always @(negedge clk_i) begin
        bit        expWe;
        bit        expHit;
        bit [31:0] expFwd;
        bit        doPush;
        bit        doPop;
        entry_t    e;
        #2;
        if (checkEn) begin
            expWe  = 1'b0;
            expHit = 1'b0;
            expFwd = 32'd0;
            if (modelQ.size() > 0) begin
                expWe = modelQ[0].we && (modelQ[0].waddr != 0) && rf_port_free_i && !flush_i;
            end
            for (int i = modelQ.size() - 1; i >= 0; i--) begin
                if (!expHit && fwd_raddr_i != 0 && modelQ[i].we && modelQ[i].waddr == fwd_raddr_i) begin
                    expHit = 1'b1;
                    expFwd = modelQ[i].data;
                end
            end
            checkOutput("ex_ready", 32'(ex_ready_o), 32'(modelQ.size() != DEPTH));
            checkOutput("empty", 32'(empty_o), 32'(modelQ.size() == 0));
            checkOutput("rf_we", 32'(rf_we_o), 32'(expWe));
            checkOutput("fwd_hit", 32'(fwd_hit_o), 32'(expHit));
            checkOutput("fwd_data", fwd_data_o, expFwd);
            checkOutput("retired", retired_o, modelRetired);
`ifdef WB_SECURE_CLEAR_EN
            checkOutput("rf_waddr", 32'(rf_waddr_o), expWe ? 32'(modelQ[0].waddr) : 32'd0);
            checkOutput("rf_wdata", rf_wdata_o, expWe ? modelQ[0].data : 32'd0);
`else
            if (modelQ.size() > 0) begin
                checkOutput("rf_waddr", 32'(rf_waddr_o), 32'(modelQ[0].waddr));
                checkOutput("rf_wdata", rf_wdata_o, modelQ[0].data);
            end
`endif
        end
        if (rst_i) begin
            modelQ.delete();
            modelRetired = 0;
        end else if (flush_i) begin
            modelQ.delete();
        end else begin
            doPush = ex_valid_i && (modelQ.size() != DEPTH);
            doPop  = (modelQ.size() > 0) && rf_port_free_i;
            if (doPop) begin
                void'(modelQ.pop_front());
                modelRetired = modelRetired + 1;
            end
            if (doPush) begin
                e.we    = ex_we_i;
                e.waddr = ex_waddr_i;
                e.data  = ex_result_i;
                modelQ.push_back(e);
            end
        end
    end

    initial begin
        // Reset for two edges, then release and pin the reset values.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        checkEn = 1'b1;
        idle(1'b0, 5'd0);
        checkOutput("reset ready", 32'(ex_ready_o), 32'd1);
        checkOutput("reset empty", 32'(empty_o), 32'd1);
        checkOutput("reset rf_we", 32'(rf_we_o), 32'd0);
        checkOutput("reset rf_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("reset rf_wdata", rf_wdata_o, 32'd0);
        checkOutput("reset fwd_hit", 32'(fwd_hit_o), 32'd0);
        checkOutput("reset fwd_data", fwd_data_o, 32'd0);
        checkOutput("reset retired", retired_o, 32'd0);

        // Single result drains in the following cycle.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1, 5'd0);
        checkOutput("single rf_we", 32'(rf_we_o), 32'd1);
        checkOutput("single rf_waddr", 32'(rf_waddr_o), 32'd5);
        checkOutput("single rf_wdata", rf_wdata_o, 32'hDEADBEEF);
        idle(1'b1, 5'd0);
        checkOutput("single retired", retired_o, 32'd1);

        // Fill while the LSU holds the port, then drain in order.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(1'b0, 5'd0);
        checkOutput("full ready", 32'(ex_ready_o), 32'd0);
        idle(1'b1, 5'd0);
        checkOutput("drain0 rf_wdata", rf_wdata_o, 32'h11);
        checkOutput("drain0 rf_we", 32'(rf_we_o), 32'd1);
        idle(1'b1, 5'd0);
        checkOutput("drain1 rf_wdata", rf_wdata_o, 32'h22);
        checkOutput("drain1 rf_we", 32'(rf_we_o), 32'd1);
        idle(1'b1, 5'd0);
        checkOutput("drain retired", retired_o, 32'd3);

        // Youngest match wins; address zero never hits.
        applyStimulus(1'b1, 1'b1, 5'd7, 32'hA, 1'b0, 1'b0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'hB, 1'b0, 1'b0, 5'd0, 1'b0);
        idle(1'b0, 5'd7);
        checkOutput("fwd7 hit", 32'(fwd_hit_o), 32'd1);
        checkOutput("fwd7 data", fwd_data_o, 32'hB);
        idle(1'b0, 5'd0);
        checkOutput("fwd0 hit", 32'(fwd_hit_o), 32'd0);
        checkOutput("fwd0 data", fwd_data_o, 32'd0);

        // Flush with a concurrent push: nothing written, nothing retired.
        applyStimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd0, 1'b0);
        checkOutput("flush rf_we", 32'(rf_we_o), 32'd0);
        idle(1'b1, 5'd7);
        checkOutput("flush empty", 32'(empty_o), 32'd1);
        checkOutput("flush retired", retired_o, 32'd3);
        checkOutput("flush fwd_hit", 32'(fwd_hit_o), 32'd0);
`ifdef WB_SECURE_CLEAR_EN
        checkOutput("flush rf_wdata", rf_wdata_o, 32'd0);
`endif

        // Write to x0 retires without a strobe.
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(1'b1, 5'd0);
        checkOutput("x0 rf_we", 32'(rf_we_o), 32'd0);
        idle(1'b1, 5'd0);
        checkOutput("x0 retired", retired_o, 32'd4);

        // Six back-to-back results with the port free: one write per cycle.
        for (int i = 0; i <= 6; i++) begin
            applyStimulus(i < 6, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 1'b0, 5'd0, 1'b0);
            if (i > 0) begin
                checkOutput("b2b rf_we", 32'(rf_we_o), 32'd1);
                checkOutput("b2b rf_wdata", rf_wdata_o, 32'h100 + 32'(i - 1));
            end
        end
        idle(1'b1, 5'd0);
        checkOutput("b2b retired", retired_o, 32'd10);

        // Randomized traffic including occasional flush and mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 85,
                          5'($urandom_range(0, 7)),
                          $urandom,
                          $urandom_range(0, 99) < 60,
                          $urandom_range(0, 99) < 5,
                          5'($urandom_range(0, 7)),
                          $urandom_range(0, 499) == 0);
        end
        idle(1'b1, 5'd0);
        idle(1'b1, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ibex_wb_buffer.md
# ibex_wb_buffer

Writeback buffer that sits directly downstream of the execution stage. It accepts completed ALU and mult/div results, holds them in a 2-entry in-order FIFO, and drains them to the register-file write port. Draining stalls while the LSU owns that port. The block also provides a forwarding lookup for the ID stage and counts retired results.

## Interface
Parameters:
- `Depth`, default 2. Number of FIFO entries; legal values are 2 and 4.
- `CountWidth`, default 32. Width of the retired-result counter.

Ports:
- `clk_i`, in, 1. Single clock.
- `rst_i`, in, 1. Reset; synchronous, active-high.
- `ex_valid_i`, in, 1. EX has a final result this cycle.
- `ex_result_i`, in, 32. Result value.
- `ex_waddr_i`, in, 5. Destination register.
- `ex_we_i`, in, 1. Result targets the register file (0 means retire only).
- `ex_ready_o`, out, 1. Buffer can accept this cycle.
- `rf_we_o`, out, 1. Register-file write strobe.
- `rf_waddr_o`, out, 5. Write address.
- `rf_wdata_o`, out, 32. Write data.
- `rf_port_free_i`, in, 1. The LSU is not using the write port this cycle.
- `flush_i`, in, 1. Discard all buffered entries (exception or branch kill).
- `fwd_raddr_i`, in, 5. Forwarding lookup address.
- `fwd_hit_o`, out, 1. A buffered entry matches the lookup.
- `fwd_data_o`, out, 32. Data of the youngest matching entry.
- `empty_o`, out, 1. No entries are held.
- `retired_o`, out, `CountWidth`. Running count of drained entries.

## Operation
- Each entry holds `{valid, we, waddr[4:0], data[31:0]}`. Storage is a circular buffer with head and tail pointers of width log2(`Depth`) and an occupancy counter of width log2(`Depth`)+1.
- Push:
  - Condition: `ex_valid_i & ex_ready_o & !flush_i`.
  - Action: write the entry at the tail, then advance the tail.
- `ex_ready_o` = (occupancy != `Depth`). It depends only on registered state; there is no combinational path from `rf_port_free_i`.
- Pop:
  - Condition: head valid & `rf_port_free_i` & `!flush_i`.
  - Action: advance the head and increment `retired_o`. The increment wraps modulo 2^`CountWidth`.
- Drive from the head entry:
  - `rf_we_o` = head valid & head.we & (head.waddr != 0) & `rf_port_free_i`.
  - `rf_waddr_o` and `rf_wdata_o` come from the head entry.
- Entries with we=0 or waddr=0 still pop and still count as retired; they produce no write strobe.
- Push and pop in the same cycle leave occupancy unchanged. When full, a pop does not open space until the next cycle, because ready is registered-state based.
- Forwarding:
  - Compare `fwd_raddr_i` against all valid entries with we=1 and waddr≠0.
  - On multiple matches, select the youngest, i.e. the entry closest to the tail.
  - `fwd_raddr_i`=0 never hits.
  - If there is no hit, `fwd_data_o`=0.
- Flush:
  - Next cycle: all valid bits are 0, the pointers are 0, and occupancy is 0.
  - Flush takes priority over a same-cycle push and pop. The head is not written and `retired_o` does not increment.
  - `rf_we_o` is forced to 0 in the flush cycle.

## Timing
- Latency: a push in cycle N gives `rf_we_o` in cycle N+1 at the earliest.
- Throughput: one result per cycle while `rf_port_free_i`=1.
- Combinational paths:
  - `rf_*` depend on `rf_port_free_i` and `flush_i` only.
  - `fwd_*` depend on `fwd_raddr_i` only.
- Reset: all entries are invalid with data 0, the pointers and occupancy are 0, and `retired_o`=0. This gives `ex_ready_o`=1, `empty_o`=1, `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, `fwd_hit_o`=0 and `fwd_data_o`=0.
- Reset mid-operation discards all entries without writing them and does not count them.
- Pointer wrap: both pointers wrap from `Depth`-1 to 0.

## Configuration
- Macro: `WB_SECURE_CLEAR_EN`.
- Defined:
  - A popped or flushed entry has its data and waddr fields zeroed in the same update.
  - `rf_wdata_o` and `rf_waddr_o` are 0 whenever `rf_we_o`=0.
  - Stale operand values therefore never persist in the buffer or toggle on the port.
- Undefined:
  - Freed entries keep their stale data.
  - `rf_wdata_o` and `rf_waddr_o` always reflect the head entry, even when `rf_we_o`=0.
- Functional results, meaning write strobes, retire counts and forwarding hits, are identical in both builds.

## Test plan
- Reset, then push {we=1, waddr=5, data=0xDEADBEEF} with port free: `rf_we_o`=1 with waddr=5 and data 0xDEADBEEF in the next cycle; `retired_o`=1 after it.
- Hold `rf_port_free_i`=0 and push 0x11 then 0x22 (waddr 3 and 4): `ex_ready_o`=0 once full. Release the port: writes 0x11 then 0x22 occur on consecutive cycles in order; `retired_o`=2.
- Hold 2 entries both with waddr=7 (0xA, then 0xB) and set `fwd_raddr_i`=7: `fwd_hit_o`=1, `fwd_data_o`=0xB. With `fwd_raddr_i`=0: `fwd_hit_o`=0.
- Push {we=1, waddr=0, data=0x55}: `rf_we_o` is never asserted; `retired_o` increments by 1.
- With 2 entries and `flush_i`=1 alongside `ex_valid_i`=1: next cycle `empty_o`=1 and `retired_o` is unchanged; no write occurs. With `WB_SECURE_CLEAR_EN` defined, internal data reads 0.
- Run 6 back-to-back pushes with the port always free: the pointers wrap, all 6 results are written in order at one per cycle, and `retired_o`=6.
